// File: rtl/err_estimat_mc.sv
// Multi-channel error estimator: per channel s1 = (K0*nv + K1*nu + K2*no) >>> FRAC,
// result s1 - nleak, falling back to max(nu - nleak, 0) on arithmetic error or in bypass mode.
module err_estimat_mc #(
  parameter int                       NCH    = 4,
  parameter int                       CNT_W  = 25,
  parameter int                       COEF_W = 32,
  parameter logic signed [COEF_W-1:0] K0     = 483207710,
  parameter logic signed [COEF_W-1:0] K1     = -5592433,
  parameter logic signed [COEF_W-1:0] K2     = 827155766,
  parameter int                       FRAC   = 22,
  parameter int                       OUT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_mode,
  input  logic [NCH*CNT_W-1:0]   i_nv,
  input  logic [NCH*CNT_W-1:0]   i_nu,
  input  logic [NCH*CNT_W-1:0]   i_no,
  input  logic [NCH*OUT_W-1:0]   i_nleak,
  output logic [OUT_W-1:0]       o_value,
  output logic [2:0]             o_ch,
  output logic                   o_vld,
  output logic                   o_err,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_start_drop
);

  localparam int ACC_W = COEF_W + CNT_W + 3;
  localparam int BIT_W = $clog2(CNT_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL, S_FIN} state_e;

  state_e                    state_q, state_d;
  logic [2:0]                ch_q, ch_d;
  logic [1:0]                term_q, term_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]          mplier_q, mplier_d;
  logic                      mode_q;
  logic [NCH*CNT_W-1:0]      nv_q, nu_q, no_q;
  logic [NCH*OUT_W-1:0]      nleak_q;
  logic [OUT_W-1:0]          value_q, value_d;
  logic [2:0]                och_q, och_d;
  logic                      vld_q, vld_d, err_q, err_d, done_q, done_d, drop_q, drop_d;
  logic                      cap;

  logic [CNT_W-1:0]          cnt_sel, nu_ch;
  logic [OUT_W-1:0]          leak_ch, fb_val;
  logic signed [COEF_W-1:0]  k_sel;
  logic signed [ACC_W-1:0]   mcand_cur, partial, s1, leak_ext, nu_ext, l_c, fb_c;
  logic [CNT_W-1:0]          mplier_cur;
  logic                      err_c, last_ch;

  // Operand selection and the FIN-stage arithmetic, all from registered state.
  always_comb begin
    unique case (term_q)
      2'd0:    begin cnt_sel = nv_q[int'(ch_q)*CNT_W +: CNT_W]; k_sel = K0; end
      2'd1:    begin cnt_sel = nu_q[int'(ch_q)*CNT_W +: CNT_W]; k_sel = K1; end
      default: begin cnt_sel = no_q[int'(ch_q)*CNT_W +: CNT_W]; k_sel = K2; end
    endcase
    // First bit of a term takes operands straight from the coefficient/count, so no load cycle.
    mcand_cur  = (bit_q == '0) ? {{(ACC_W-COEF_W){k_sel[COEF_W-1]}}, k_sel} : mcand_q;
    mplier_cur = (bit_q == '0) ? cnt_sel : mplier_q;
    partial    = mplier_cur[0] ? mcand_cur : '0;

    nu_ch    = nu_q[int'(ch_q)*CNT_W +: CNT_W];
    leak_ch  = nleak_q[int'(ch_q)*OUT_W +: OUT_W];
    s1       = acc_q >>> FRAC;
    leak_ext = {{(ACC_W-OUT_W){1'b0}}, leak_ch};
    nu_ext   = {{(ACC_W-CNT_W){1'b0}}, nu_ch};
    l_c      = s1 - leak_ext;
    fb_c     = nu_ext - leak_ext;
    fb_val   = fb_c[ACC_W-1] ? '0 : fb_c[OUT_W-1:0];
    err_c    = (s1 <= 0) || (|s1[ACC_W-1:OUT_W]) || l_c[ACC_W-1];
    last_ch  = (ch_q == 3'(NCH-1));
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    term_d   = term_q;
    bit_d    = bit_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    value_d  = value_q;
    och_d    = och_q;
    err_d    = err_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    drop_d   = i_start && (state_q != S_IDLE);
    cap      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cap     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ch_d    = '0;
        term_d  = '0;
        bit_d   = '0;
        acc_d   = '0;
        state_d = mode_q ? S_FIN : S_MUL;
      end
      S_MUL: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_cur <<< 1;
        mplier_d = mplier_cur >> 1;
        if (bit_q == BIT_W'(CNT_W-1)) begin
          bit_d = '0;
          if (term_q == 2'd2) begin
            term_d  = '0;
            state_d = S_FIN;
          end else begin
            term_d = term_q + 2'd1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin // S_FIN
        vld_d   = 1'b1;
        och_d   = ch_q;
        done_d  = last_ch;
        acc_d   = '0;
        value_d = (mode_q || err_c) ? fb_val : l_c[OUT_W-1:0];
        err_d   = !mode_q && err_c;
        if (last_ch) begin
          state_d = S_IDLE;
        end else begin
          ch_d    = ch_q + 3'd1;
          state_d = mode_q ? S_FIN : S_MUL;
        end
      end
    endcase

    // Abort discards the channel in flight; the previous result stays on o_value.
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      acc_d   = '0;
      vld_d   = 1'b0;
      done_d  = 1'b0;
      value_d = value_q;
      och_d   = och_q;
      err_d   = err_q;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      term_q   <= '0;
      bit_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mode_q   <= 1'b0;
      nv_q     <= '0;
      nu_q     <= '0;
      no_q     <= '0;
      nleak_q  <= '0;
      value_q  <= '0;
      och_q    <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      term_q   <= term_d;
      bit_q    <= bit_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      value_q  <= value_d;
      och_q    <= och_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      if (cap) begin
        mode_q  <= i_mode;
        nv_q    <= i_nv;
        nu_q    <= i_nu;
        no_q    <= i_no;
        nleak_q <= i_nleak;
      end
    end
  end

  assign o_value      = value_q;
  assign o_ch         = och_q;
  assign o_vld        = vld_q;
  assign o_err        = err_q;
  assign o_done       = done_q;
  assign o_start_drop = drop_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule
